// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the LCD bus monitor: HD44780 command
//                opcode masks/patterns, DDRAM line geometry, controller state
//                encoding and the DDRAM address-counter wrap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // DDRAM line geometry (2-line mode): each line spans 40 addresses.
    localparam logic [6:0] c_line1_base = 7'h00;
    localparam logic [6:0] c_line1_end  = 7'h27;
    localparam logic [6:0] c_line2_base = 7'h40;
    localparam logic [6:0] c_line2_end  = 7'h67;
    localparam int         VISIBLE_COLS = 16;

    // Shadow clear walks all 32 visible cells; home holds busy for 2 cycles.
    localparam logic [4:0] c_clear_last = 5'd31;
    localparam logic [4:0] c_home_last  = 5'd1;

    // Command opcodes: a command matches when (data & mask) == pattern.
    // Checked from the highest set bit downwards.
    localparam logic [7:0] c_op_ddram_mask = 8'h80, c_op_ddram_pat = 8'h80;
    localparam logic [7:0] c_op_cgram_mask = 8'hC0, c_op_cgram_pat = 8'h40;
    localparam logic [7:0] c_op_func_mask  = 8'hE0, c_op_func_pat  = 8'h20;
    localparam logic [7:0] c_op_shift_mask = 8'hF0, c_op_shift_pat = 8'h10;
    localparam logic [7:0] c_op_disp_mask  = 8'hF8, c_op_disp_pat  = 8'h08;
    localparam logic [7:0] c_op_entry_mask = 8'hFC, c_op_entry_pat = 8'h04;
    localparam logic [7:0] c_op_home_mask  = 8'hFE, c_op_home_pat  = 8'h02;
    localparam logic [7:0] c_op_clear_mask = 8'hFF, c_op_clear_pat = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        HOME  = 2'd2
    } lcd_state_t;

    // Address counter step with the HD44780 2-line wrap:
    // inc: 0x27 -> 0x40, 0x67 -> 0x00; dec: 0x40 -> 0x27, 0x00 -> 0x67.
    function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
        logic [6:0] w_next;
        if (inc) begin
            if (addr == c_line1_end)      w_next = c_line2_base;
            else if (addr == c_line2_end) w_next = c_line1_base;
            else                          w_next = addr + 7'd1;
        end else begin
            if (addr == c_line2_base)     w_next = c_line1_end;
            else if (addr == c_line1_base) w_next = c_line2_end;
            else                          w_next = addr - 7'd1;
        end
        return w_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_sync
//  Description : Brings the asynchronous LCD bus into the clk domain, measures
//                how long E stays high and qualifies each E falling edge as
//                either a transaction or a glitch.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n        clock, synchronous active-low reset
//                lcd_e/rs/data     raw LCD bus
//                tx_valid          1-cycle pulse: qualified falling edge
//                tx_rs, tx_data    last {rs,data} latched while E was high
//                glitch_evt        1-cycle pulse: E high pulse too short
// ============================================================================
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic [7:0] lcd_data,
    output logic       tx_valid,
    output logic       tx_rs,
    output logic [7:0] tx_data,
    output logic       glitch_evt
);

    localparam int                c_cnt_w   = $clog2(MIN_E_HIGH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(MIN_E_HIGH);

    // Each stage carries {e, rs, data[7:0]}.
    logic [SYNC_STAGES-1:0][9:0] r_sync;
    logic                        r_e_prev;
    logic                        r_cap_rs;
    logic [7:0]                  r_cap_data;
    logic [c_cnt_w-1:0]          r_cnt;

    logic       w_e_s;
    logic       w_rs_s;
    logic [7:0] w_data_s;
    logic       w_fall;

    assign w_e_s    = r_sync[SYNC_STAGES-1][9];
    assign w_rs_s   = r_sync[SYNC_STAGES-1][8];
    assign w_data_s = r_sync[SYNC_STAGES-1][7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_e_prev   <= 1'b0;
            r_cap_rs   <= 1'b0;
            r_cap_data <= 8'h00;
            r_cnt      <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], {lcd_e, lcd_rs, lcd_data}};
            r_e_prev <= w_e_s;
            if (w_e_s) begin
                // Keep the most recent bus value; the writer may settle late.
                r_cap_rs   <= w_rs_s;
                r_cap_data <= w_data_s;
                // Saturating at the threshold is enough to decide >= MIN_E_HIGH.
                if (r_cnt != c_cnt_sat) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // r_cnt still holds the completed high time in the falling-edge cycle.
    assign w_fall     = r_e_prev & ~w_e_s;
    assign tx_valid   = w_fall & (r_cnt == c_cnt_sat);
    assign glitch_evt = w_fall & (r_cnt != c_cnt_sat);
    assign tx_rs      = r_cap_rs;
    assign tx_data    = r_cap_data;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_monitor
//  Description : HD44780-style bus receiver. Decodes commands and character
//                writes into a 2x16 shadow DDRAM, address counter and mode
//                bits so on-chip logic can read back what the panel shows.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n          clock, synchronous active-low reset
//                lcd_e/rs/data       LCD bus (asynchronous)
//                rd_addr / rd_char   shadow read port (registered)
//                clr_flags           clears overrun and glitch
//                cursor_addr         DDRAM address counter
//                display_on, cursor_on, blink_on, entry_inc, func_bits
//                busy                clear or home in progress
//                wr_strobe           pulse per accepted transaction
//                overrun, glitch     sticky error flags
// ============================================================================
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_E_HIGH  = 4,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    input  logic       clr_flags,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic [2:0] func_bits,
    output logic       busy,
    output logic       wr_strobe,
    output logic       overrun,
    output logic       glitch
);

    localparam logic [5:0] c_visible_cols = 6'(VISIBLE_COLS);

    logic       w_tx_valid;
    logic       w_tx_rs;
    logic [7:0] w_tx_data;
    logic       w_glitch_evt;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_E_HIGH  (MIN_E_HIGH)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data),
        .tx_valid   (w_tx_valid),
        .tx_rs      (w_tx_rs),
        .tx_data    (w_tx_data),
        .glitch_evt (w_glitch_evt)
    );

    lcd_state_t r_state, w_state_next;
    logic [4:0] r_idx, w_idx_next;
    logic [6:0] r_cursor, w_cursor_next;
    logic       r_display_on, w_display_next;
    logic       r_cursor_on, w_cursor_on_next;
    logic       r_blink_on, w_blink_next;
    logic       r_entry_inc, w_entry_next;
    logic [2:0] r_func, w_func_next;
    logic       r_strobe, w_strobe_next;
    logic       r_overrun, w_overrun_next;
    logic       r_glitch, w_glitch_next;
    logic [7:0] r_rd_char;
    logic [7:0] r_mem [32];

    logic       w_busy;
    logic       w_mem_we;
    logic [4:0] w_mem_widx;
    logic [7:0] w_mem_wdata;
    logic       w_visible;
    logic [5:0] w_dd_low;

    assign w_busy    = (r_state != IDLE);
    // Visible cells are columns 0-15 of either line; bit 6 selects the line.
    assign w_visible = (r_cursor[5:0] < c_visible_cols);
    // Set-DDRAM beyond the line end lands on the start of that line.
    assign w_dd_low  = (w_tx_data[5:0] > c_line1_end[5:0]) ? 6'd0 : w_tx_data[5:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset kicks off a full shadow clear.
            r_state      <= CLEAR;
            r_idx        <= 5'd0;
            r_cursor     <= 7'h00;
            r_display_on <= 1'b0;
            r_cursor_on  <= 1'b0;
            r_blink_on   <= 1'b0;
            r_entry_inc  <= 1'b1;
            r_func       <= 3'b011;
            r_strobe     <= 1'b0;
            r_overrun    <= 1'b0;
            r_glitch     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_cursor     <= w_cursor_next;
            r_display_on <= w_display_next;
            r_cursor_on  <= w_cursor_on_next;
            r_blink_on   <= w_blink_next;
            r_entry_inc  <= w_entry_next;
            r_func       <= w_func_next;
            r_strobe     <= w_strobe_next;
            r_overrun    <= w_overrun_next;
            r_glitch     <= w_glitch_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_cursor_next    = r_cursor;
        w_display_next   = r_display_on;
        w_cursor_on_next = r_cursor_on;
        w_blink_next     = r_blink_on;
        w_entry_next     = r_entry_inc;
        w_func_next      = r_func;
        w_strobe_next    = 1'b0;
        w_overrun_next   = r_overrun;
        w_glitch_next    = r_glitch;
        w_mem_we         = 1'b0;
        w_mem_widx       = r_idx;
        w_mem_wdata      = CLEAR_CHAR;

        // Set events are applied after the clear so they win.
        if (clr_flags) begin
            w_overrun_next = 1'b0;
            w_glitch_next  = 1'b0;
        end
        if (w_glitch_evt) begin
            w_glitch_next = 1'b1;
        end
        if (w_tx_valid && w_busy) begin
            w_overrun_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_tx_valid) begin
                    w_strobe_next = 1'b1;
                    if (w_tx_rs) begin
                        // Off-screen writes are discarded but still move the cursor.
                        if (w_visible) begin
                            w_mem_we    = 1'b1;
                            w_mem_widx  = {r_cursor[6], r_cursor[3:0]};
                            w_mem_wdata = w_tx_data;
                        end
                        w_cursor_next = addr_step(r_cursor, r_entry_inc);
                    end else if ((w_tx_data & c_op_ddram_mask) == c_op_ddram_pat) begin
                        w_cursor_next = {w_tx_data[6], w_dd_low};
                    end else if ((w_tx_data & c_op_cgram_mask) == c_op_cgram_pat) begin
                        // CGRAM is not shadowed.
                    end else if ((w_tx_data & c_op_func_mask) == c_op_func_pat) begin
                        w_func_next = w_tx_data[4:2];
                    end else if ((w_tx_data & c_op_shift_mask) == c_op_shift_pat) begin
                        // Display shift (bit 3) has no effect on the shadow.
                        if (!w_tx_data[3]) begin
                            w_cursor_next = addr_step(r_cursor, w_tx_data[2]);
                        end
                    end else if ((w_tx_data & c_op_disp_mask) == c_op_disp_pat) begin
                        w_display_next   = w_tx_data[2];
                        w_cursor_on_next = w_tx_data[1];
                        w_blink_next     = w_tx_data[0];
                    end else if ((w_tx_data & c_op_entry_mask) == c_op_entry_pat) begin
                        w_entry_next = w_tx_data[1];
                    end else if ((w_tx_data & c_op_home_mask) == c_op_home_pat) begin
                        w_cursor_next = 7'h00;
                        w_state_next  = HOME;
                        w_idx_next    = 5'd0;
                    end else if ((w_tx_data & c_op_clear_mask) == c_op_clear_pat) begin
                        w_state_next = CLEAR;
                        w_idx_next   = 5'd0;
                    end
                end
            end
            CLEAR: begin
                w_mem_we = 1'b1;
                if (r_idx == c_clear_last) begin
                    w_state_next  = IDLE;
                    w_idx_next    = 5'd0;
                    w_cursor_next = 7'h00;
                    w_entry_next  = 1'b1;
                end else begin
                    w_idx_next = r_idx + 5'd1;
                end
            end
            HOME: begin
                if (r_idx == c_home_last) begin
                    w_state_next = IDLE;
                    w_idx_next   = 5'd0;
                end else begin
                    w_idx_next = r_idx + 5'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 5'd0;
            end
        endcase
    end

    // Shadow array: no reset, contents are established by the clear sequence.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    // Read-before-write: mid-clear reads see old data for uncleared cells.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_char <= 8'h00;
        end else begin
            r_rd_char <= r_mem[rd_addr];
        end
    end

    assign rd_char     = r_rd_char;
    assign cursor_addr = r_cursor;
    assign display_on  = r_display_on;
    assign cursor_on   = r_cursor_on;
    assign blink_on    = r_blink_on;
    assign entry_inc   = r_entry_inc;
    assign func_bits   = r_func;
    assign busy        = w_busy;
    assign wr_strobe   = r_strobe;
    assign overrun     = r_overrun;
    assign glitch      = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_bus_monitor
//  Description : Directed self-checking bench for lcd_bus_monitor. Every bus
//                write pushes the cursor address expected after it onto a
//                scoreboard queue; each wr_strobe pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_E_HIGH  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_e;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       clr_flags;
    logic [6:0] cursor_addr;
    logic       display_on;
    logic       cursor_on;
    logic       blink_on;
    logic       entry_inc;
    logic [2:0] func_bits;
    logic       busy;
    logic       wr_strobe;
    logic       overrun;
    logic       glitch;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    logic [6:0] exp_q [$];

    always #5 clk = ~clk;

    lcd_bus_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_E_HIGH  (MIN_E_HIGH),
        .CLEAR_CHAR  (8'h20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .clr_flags   (clr_flags),
        .cursor_addr (cursor_addr),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .entry_inc   (entry_inc),
        .func_bits   (func_bits),
        .busy        (busy),
        .wr_strobe   (wr_strobe),
        .overrun     (overrun),
        .glitch      (glitch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one pop per accepted transaction.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobes++;
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("strobe_cursor", 32'(cursor_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    // E high for hi cycles, then low for lo cycles.
    task automatic bus_write(input logic rs, input logic [7:0] d, input int hi, input int lo,
                             input bit accept, input logic [6:0] exp_cur);
        @(negedge clk);
        if (accept) exp_q.push_back(exp_cur);
        lcd_rs   = rs;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic read_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(tag, 32'(rd_char), 32'(exp));
    endtask

    task automatic busy_window(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk(tag, 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] park [14];
        park = '{8'h50, 8'h61, 8'h72, 8'h6B, 8'h69, 8'h6E, 8'h67,
                 8'h20, 8'h53, 8'h79, 8'h73, 8'h74, 8'h65, 8'h6D};

        rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_data = 8'h00;
        rd_addr = 5'd0; clr_flags = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_rd_char", 32'(rd_char), 32'h00);
        chk("rst_cursor", 32'(cursor_addr), 32'h00);
        chk("rst_modes", 32'({display_on, cursor_on, blink_on, entry_inc}), 32'b0001);
        chk("rst_func", 32'(func_bits), 32'b011);
        chk("rst_flags", 32'({wr_strobe, overrun, glitch}), 32'b000);

        rst_n = 1'b1;
        busy_window("busy_init");
        for (int i = 0; i < 32; i++) begin
            read_chk(5'(i), 8'h20, "init_clear_char");
        end
        chk("init_cursor", 32'(cursor_addr), 32'h00);
        chk("init_func", 32'(func_bits), 32'b011);

        // Init sequence and "Parking System"
        bus_write(1'b0, 8'h38, 50, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h0C, 50, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h06, 50, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h01, 50, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h80, 50, 10, 1'b1, 7'h00);
        for (int i = 0; i < 14; i++) begin
            bus_write(1'b1, park[i], 50, 10, 1'b1, 7'(i + 1));
        end
        for (int i = 0; i < 14; i++) begin
            read_chk(5'(i), park[i], "park_text");
        end
        chk("park_cursor", 32'(cursor_addr), 32'h0E);
        chk("park_modes", 32'({display_on, cursor_on, entry_inc}), 32'b101);
        chk("park_func", 32'(func_bits), 32'b110);
        chk("park_strobes", 32'(strobes), 32'd19);

        // Line 2 write, off-screen writes and line wraps
        bus_write(1'b0, 8'hC0, 6, 10, 1'b1, 7'h40);
        bus_write(1'b1, 8'h41, 6, 10, 1'b1, 7'h41);
        bus_write(1'b0, 8'hA7, 6, 10, 1'b1, 7'h27);
        bus_write(1'b1, 8'h42, 6, 10, 1'b1, 7'h40);
        bus_write(1'b0, 8'hE7, 6, 10, 1'b1, 7'h67);
        bus_write(1'b1, 8'h42, 6, 10, 1'b1, 7'h00);
        read_chk(5'd16, 8'h41, "line2_char");
        read_chk(5'd17, 8'h20, "line2_untouched");
        read_chk(5'd0, 8'h50, "offscreen_dropped");
        chk("wrap_cursor", 32'(cursor_addr), 32'h00);

        // Decrement mode, wrap 0x00 -> 0x67
        bus_write(1'b0, 8'h04, 6, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h80, 6, 10, 1'b1, 7'h00);
        bus_write(1'b1, 8'h58, 6, 10, 1'b1, 7'h67);
        read_chk(5'd0, 8'h58, "dec_write");
        chk("dec_entry", 32'(entry_inc), 32'd0);
        chk("dec_cursor", 32'(cursor_addr), 32'h67);

        // Cursor shifts, display control, CGRAM, no-op, home
        bus_write(1'b0, 8'h14, 6, 10, 1'b1, 7'h00);
        bus_write(1'b0, 8'h10, 6, 10, 1'b1, 7'h67);
        bus_write(1'b0, 8'h18, 6, 10, 1'b1, 7'h67);
        bus_write(1'b0, 8'h0F, 6, 10, 1'b1, 7'h67);
        chk("disp_all_on", 32'({display_on, cursor_on, blink_on}), 32'b111);
        bus_write(1'b0, 8'h40, 6, 10, 1'b1, 7'h67);
        bus_write(1'b0, 8'h00, 6, 10, 1'b1, 7'h67);
        bus_write(1'b0, 8'h02, 6, 0, 1'b1, 7'h00);
        repeat (SYNC_STAGES + 1) @(negedge clk);
        chk("home_busy_0", 32'(busy), 32'd1);
        @(negedge clk);
        chk("home_busy_1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("home_busy_done", 32'(busy), 32'd0);

        // Overrun while clearing; set beats clr_flags in the same cycle
        bus_write(1'b0, 8'h01, 6, 1, 1'b1, 7'h00);
        bus_write(1'b1, 8'h33, 5, 4, 1'b0, 7'h00);
        chk("overrun_set", 32'(overrun), 32'd1);
        @(negedge clk);
        lcd_rs = 1'b1; lcd_data = 8'h34; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        lcd_e = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("overrun_set_wins", 32'(overrun), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        repeat (40) @(negedge clk);
        chk("clear_done_busy", 32'(busy), 32'd0);
        chk("clear_exit_state", 32'({cursor_addr, entry_inc}), 32'h01);
        read_chk(5'd0, 8'h20, "clear_cmd_char");

        // Short E pulse: glitch, nothing decoded
        bus_write(1'b1, 8'h5A, 2, 10, 1'b0, 7'h00);
        chk("glitch_set", 32'(glitch), 32'd1);
        chk("glitch_cursor", 32'(cursor_addr), 32'h00);
        read_chk(5'd0, 8'h20, "glitch_no_write");
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("glitch_cleared", 32'(glitch), 32'd0);

        // Reset in the middle of a clear restarts it
        bus_write(1'b0, 8'h01, 6, 0, 1'b1, 7'h00);
        repeat (SYNC_STAGES + 11) @(negedge clk);
        chk("midclear_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midclear_rst_disp", 32'(display_on), 32'd0);
        rst_n = 1'b1;
        busy_window("busy_restart");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
